id_ex_stage: RTL and testbench

- ID→EX pipeline boundary of the 5-stage RISC-V core.
- Registers the instruction decoder's control bundle together with the ID-stage datapath values (PC, register operands, immediate, register indices).
- Detects load-use hazards against the instruction currently in EX and requests a one-cycle stall.
- Applies flush, stall and bubble insertion, and counts inserted bubbles for the perf/debug readout.

---
 rtl/id_ex_stage_pkg.sv | 44 ++++
 rtl/id_ex_stage_hazard_detect.sv | 27 ++
 rtl/id_ex_stage.sv | 147 ++++++++++++++
 tb/tb_id_ex_stage.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared encodings for the ID/EX boundary: decoder control bundle layout,
// "no-op" encodings and the all-zero bubble value.
package id_ex_stage_pkg;

   localparam logic [2:0] NOREGWRITE  = 3'd0;
   localparam logic [2:0] REGWRITE_W  = 3'd1;
   localparam logic [2:0] REGWRITE_LW = 3'd2;
   localparam logic [2:0] NOBRANCH    = 3'd0;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_SLL  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_SLT  = 4'd8;
   localparam logic [3:0] ALU_SLTU = 4'd9;

   localparam logic       ALUSRC1_RS1  = 1'b0;
   localparam logic       ALUSRC1_PC   = 1'b1;
   localparam logic [1:0] ALUSRC2_RS2  = 2'd0;
   localparam logic [1:0] ALUSRC2_IMM  = 2'd1;
   localparam logic [1:0] ALUSRC2_FOUR = 2'd2;

   typedef struct packed {
      logic       jal;
      logic       jalr;
      logic       memtoreg;
      logic       loadnpc;
      logic       alusrc1;
      logic [2:0] regwrite;
      logic [3:0] memwrite;
      logic [1:0] regread;
      logic [2:0] branchtype;
      logic [3:0] aluctrl;
      logic [1:0] alusrc2;
   } ctrl_t;

   // Every control field zero: no write, no branch, no memory access.
   localparam ctrl_t BUBBLE_CTRL = '0;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Pure combinational load-use comparator between the EX-stage load and the
// ID-stage source operands; shared with the forwarding unit.
module hazard_detect
   import id_ex_stage_pkg::*;
(
   input  logic       ex_valid,
   input  logic       ex_memtoreg,
   input  logic [2:0] ex_regwrite,
   input  logic [4:0] ex_rd,
   input  logic       id_valid,
   input  logic [1:0] id_regread,
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   output logic       hazard
);

   logic ex_is_load;
   logic rs1_hit;
   logic rs2_hit;

   // x0 is never a real destination, so a load to x0 cannot create a hazard.
   assign ex_is_load = ex_valid & ex_memtoreg & (ex_regwrite != NOREGWRITE) & (ex_rd != 5'd0);
   assign rs1_hit    = id_regread[1] & (id_rs1 == ex_rd);
   assign rs2_hit    = id_regread[0] & (id_rs2 == ex_rd);
   assign hazard     = ex_is_load & id_valid & (rs1_hit | rs2_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with load-use bubble insertion, flush/stall
// handling and a saturating count of inserted bubbles.
module id_ex_stage
   import id_ex_stage_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ex_stall,
   input  logic             ex_flush,
   input  logic             id_valid,
   input  logic [XLEN-1:0]  id_pc,
   input  logic [XLEN-1:0]  id_rd1,
   input  logic [XLEN-1:0]  id_rd2,
   input  logic [XLEN-1:0]  id_imm,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic [4:0]       id_rd,
   input  logic             id_jal,
   input  logic             id_jalr,
   input  logic             id_memtoreg,
   input  logic             id_loadnpc,
   input  logic             id_alusrc1,
   input  logic [2:0]       id_regwrite,
   input  logic [3:0]       id_memwrite,
   input  logic [1:0]       id_regread,
   input  logic [2:0]       id_branchtype,
   input  logic [3:0]       id_aluctrl,
   input  logic [1:0]       id_alusrc2,
   output logic             ex_valid,
   output logic [XLEN-1:0]  ex_pc,
   output logic [XLEN-1:0]  ex_rd1,
   output logic [XLEN-1:0]  ex_rd2,
   output logic [XLEN-1:0]  ex_imm,
   output logic [4:0]       ex_rs1,
   output logic [4:0]       ex_rs2,
   output logic [4:0]       ex_rd,
   output logic             ex_jal,
   output logic             ex_jalr,
   output logic             ex_memtoreg,
   output logic             ex_loadnpc,
   output logic             ex_alusrc1,
   output logic [2:0]       ex_regwrite,
   output logic [3:0]       ex_memwrite,
   output logic [1:0]       ex_regread,
   output logic [2:0]       ex_branchtype,
   output logic [3:0]       ex_aluctrl,
   output logic [1:0]       ex_alusrc2,
   output logic             loaduse_stall,
   output logic [CNT_W-1:0] bubble_cnt
);

   ctrl_t id_ctrl;
   ctrl_t ex_ctrl;
   logic  hazard;
   logic  do_hold;
   logic  do_bubble;
   logic  do_capture;

   assign id_ctrl = '{jal: id_jal, jalr: id_jalr, memtoreg: id_memtoreg, loadnpc: id_loadnpc,
                      alusrc1: id_alusrc1, regwrite: id_regwrite, memwrite: id_memwrite,
                      regread: id_regread, branchtype: id_branchtype, aluctrl: id_aluctrl,
                      alusrc2: id_alusrc2};

   hazard_detect u_hazard_detect (
      .ex_valid    (ex_valid),
      .ex_memtoreg (ex_ctrl.memtoreg),
      .ex_regwrite (ex_ctrl.regwrite),
      .ex_rd       (ex_rd),
      .id_valid    (id_valid),
      .id_regread  (id_regread),
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .hazard      (hazard)
   );

   // Handshake: id_valid marks a real instruction; it advances into EX on an
   // edge where ex_stall=0 and loaduse_stall=0. ex_flush overrides everything.
   assign loaduse_stall = hazard & ~ex_flush;

   always_comb begin
      do_hold    = 1'b0;
      do_bubble  = 1'b0;
      do_capture = 1'b0;
      if (ex_flush)           do_bubble  = 1'b1;
      else if (ex_stall)      do_hold    = 1'b1;
      else if (loaduse_stall) do_bubble  = 1'b1;
      else                    do_capture = id_valid;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid <= 1'b0;
         ex_ctrl  <= BUBBLE_CTRL;
         ex_pc    <= '0;
         ex_rd1   <= '0;
         ex_rd2   <= '0;
         ex_imm   <= '0;
         ex_rs1   <= '0;
         ex_rs2   <= '0;
         ex_rd    <= '0;
      end else if (do_capture) begin
         ex_valid <= 1'b1;
         ex_ctrl  <= id_ctrl;
         ex_pc    <= id_pc;
         ex_rd1   <= id_rd1;
         ex_rd2   <= id_rd2;
         ex_imm   <= id_imm;
         ex_rs1   <= id_rs1;
         ex_rs2   <= id_rs2;
         ex_rd    <= id_rd;
      end else if (!do_hold) begin
         // Bubble, either requested or from an empty ID slot.
         ex_valid <= 1'b0;
         ex_ctrl  <= BUBBLE_CTRL;
         ex_pc    <= '0;
         ex_rd1   <= '0;
         ex_rd2   <= '0;
         ex_imm   <= '0;
         ex_rs1   <= '0;
         ex_rs2   <= '0;
         ex_rd    <= '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         bubble_cnt <= '0;
      else if (do_bubble && (bubble_cnt != {CNT_W{1'b1}}))
         bubble_cnt <= bubble_cnt + CNT_W'(1);
   end

   assign ex_jal        = ex_ctrl.jal;
   assign ex_jalr       = ex_ctrl.jalr;
   assign ex_memtoreg   = ex_ctrl.memtoreg;
   assign ex_loadnpc    = ex_ctrl.loadnpc;
   assign ex_alusrc1    = ex_ctrl.alusrc1;
   assign ex_regwrite   = ex_ctrl.regwrite;
   assign ex_memwrite   = ex_ctrl.memwrite;
   assign ex_regread    = ex_ctrl.regread;
   assign ex_branchtype = ex_ctrl.branchtype;
   assign ex_aluctrl    = ex_ctrl.aluctrl;
   assign ex_alusrc2    = ex_ctrl.alusrc2;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomised + directed bench for id_ex_stage: a bundle-level reference model
// feeds an expected queue that a monitor drains against the DUT outputs.
module tb_id_ex_stage;

   localparam int XLEN  = 32;
   localparam int CNT_W = 4;
   localparam logic [CNT_W-1:0] CNT_MAX = 4'd15;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc, rd1, rd2, imm;
      logic [4:0]  rs1, rs2, rd;
      logic        jal, jalr, memtoreg, loadnpc, alusrc1;
      logic [2:0]  regwrite;
      logic [3:0]  memwrite;
      logic [1:0]  regread;
      logic [2:0]  branchtype;
      logic [3:0]  aluctrl;
      logic [1:0]  alusrc2;
   } bundle_t;

   typedef struct packed {
      logic             lu;
      bundle_t          ex;
      logic [CNT_W-1:0] cnt;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic ex_stall = 1'b0, ex_flush = 1'b0;
   bundle_t id_b = '0;

   logic             ex_valid, ex_jal, ex_jalr, ex_memtoreg, ex_loadnpc, ex_alusrc1;
   logic [XLEN-1:0]  ex_pc, ex_rd1, ex_rd2, ex_imm;
   logic [4:0]       ex_rs1, ex_rs2, ex_rd;
   logic [2:0]       ex_regwrite, ex_branchtype;
   logic [3:0]       ex_memwrite, ex_aluctrl;
   logic [1:0]       ex_regread, ex_alusrc2;
   logic             loaduse_stall;
   logic [CNT_W-1:0] bubble_cnt;

   int checks = 0;
   int errors = 0;
   exp_t exp_q[$];
   bundle_t m_ex = '0;
   int m_cnt = 0;

   id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .ex_stall(ex_stall), .ex_flush(ex_flush),
      .id_valid(id_b.valid), .id_pc(id_b.pc), .id_rd1(id_b.rd1), .id_rd2(id_b.rd2),
      .id_imm(id_b.imm), .id_rs1(id_b.rs1), .id_rs2(id_b.rs2), .id_rd(id_b.rd),
      .id_jal(id_b.jal), .id_jalr(id_b.jalr), .id_memtoreg(id_b.memtoreg),
      .id_loadnpc(id_b.loadnpc), .id_alusrc1(id_b.alusrc1), .id_regwrite(id_b.regwrite),
      .id_memwrite(id_b.memwrite), .id_regread(id_b.regread), .id_branchtype(id_b.branchtype),
      .id_aluctrl(id_b.aluctrl), .id_alusrc2(id_b.alusrc2),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_jal(ex_jal), .ex_jalr(ex_jalr),
      .ex_memtoreg(ex_memtoreg), .ex_loadnpc(ex_loadnpc), .ex_alusrc1(ex_alusrc1),
      .ex_regwrite(ex_regwrite), .ex_memwrite(ex_memwrite), .ex_regread(ex_regread),
      .ex_branchtype(ex_branchtype), .ex_aluctrl(ex_aluctrl), .ex_alusrc2(ex_alusrc2),
      .loaduse_stall(loaduse_stall), .bubble_cnt(bubble_cnt)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   function automatic bundle_t act_ex();
      bundle_t b;
      b = '{valid: ex_valid, pc: ex_pc, rd1: ex_rd1, rd2: ex_rd2, imm: ex_imm,
            rs1: ex_rs1, rs2: ex_rs2, rd: ex_rd, jal: ex_jal, jalr: ex_jalr,
            memtoreg: ex_memtoreg, loadnpc: ex_loadnpc, alusrc1: ex_alusrc1,
            regwrite: ex_regwrite, memwrite: ex_memwrite, regread: ex_regread,
            branchtype: ex_branchtype, aluctrl: ex_aluctrl, alusrc2: ex_alusrc2};
      return b;
   endfunction

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Random instruction; small register range so load-use pairs occur often.
   function automatic bundle_t rand_op(input logic [31:0] pc);
      bundle_t b;
      b = '0;
      b.valid      = ($urandom_range(0, 9) != 0);
      b.pc         = pc;
      b.rd1        = $urandom;
      b.rd2        = $urandom;
      b.imm        = $urandom;
      b.rs1        = 5'($urandom_range(0, 6));
      b.rs2        = 5'($urandom_range(0, 6));
      b.rd         = 5'($urandom_range(0, 6));
      b.jal        = 1'($urandom);
      b.jalr       = 1'($urandom);
      b.memtoreg   = 1'($urandom);
      b.loadnpc    = 1'($urandom);
      b.alusrc1    = 1'($urandom);
      b.regwrite   = 3'($urandom);
      b.memwrite   = 4'($urandom);
      b.regread    = 2'($urandom);
      b.branchtype = 3'($urandom);
      b.aluctrl    = 4'($urandom_range(0, 9));
      b.alusrc2    = 2'($urandom_range(0, 2));
      return b;
   endfunction

   function automatic bundle_t op(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                                  input logic [4:0] rd, input logic [1:0] regread, input logic is_load);
      bundle_t b;
      b = '0;
      b.valid    = 1'b1;
      b.pc       = pc;
      b.rd1      = $urandom;
      b.rd2      = $urandom;
      b.imm      = $urandom;
      b.rs1      = rs1;
      b.rs2      = rs2;
      b.rd       = rd;
      b.regread  = regread;
      b.memtoreg = is_load;
      b.regwrite = is_load ? 3'd2 : 3'd1;
      b.alusrc2  = is_load ? 2'd1 : 2'd0;
      return b;
   endfunction

   // ---------------- driver + reference model ----------------
   task automatic drive(input bundle_t id, input logic stall, input logic flush);
      exp_t e;
      logic lu;
      @(negedge clk);
      id_b     = id;
      ex_stall = stall;
      ex_flush = flush;
      // A load sitting in EX blocks any ID instruction that reads its destination.
      lu = !flush && m_ex.valid && m_ex.memtoreg && (m_ex.regwrite != 0) && (m_ex.rd != 0) &&
           id.valid && ((id.regread[1] && id.rs1 == m_ex.rd) || (id.regread[0] && id.rs2 == m_ex.rd));
      if (flush || (!stall && lu)) begin
         m_ex  = '0;
         m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
      end else if (!stall) begin
         m_ex = id.valid ? id : bundle_t'('0);
      end
      e.lu  = lu;
      e.ex  = m_ex;
      e.cnt = CNT_W'(m_cnt);
      exp_q.push_back(e);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      exp_q.delete();
      m_ex  = '0;
      m_cnt = 0;
      #1;
      chk("reset_ex", 256'(act_ex()), 256'(0));
      chk("reset_cnt", 256'(bubble_cnt), 256'(0));
      repeat (2) begin
         @(negedge clk);
         id_b     = rand_op($urandom);
         ex_stall = 1'($urandom);
         ex_flush = 1'($urandom);
      end
      @(posedge clk);
      #1;
      chk("reset_hold_ex", 256'(act_ex()), 256'(0));
      chk("reset_hold_cnt", 256'(bubble_cnt), 256'(0));
      @(negedge clk);
      id_b     = '0;
      ex_stall = 1'b0;
      ex_flush = 1'b0;
      rst_n    = 1'b1;
   endtask

   // ---------------- monitor / scoreboard ----------------
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #3;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("loaduse_stall", 256'(loaduse_stall), 256'(e.lu));
            @(posedge clk);
            #1;
            chk("ex_bundle", 256'(act_ex()), 256'(e.ex));
            chk("bubble_cnt", 256'(bubble_cnt), 256'(e.cnt));
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int cnt_before;
      #1;
      id_b = rand_op(32'h1234);
      do_reset();

      // First capture after reset release.
      drive(op(32'h40, 5'd1, 5'd2, 5'd3, 2'b11, 1'b0), 1'b0, 1'b0);
      @(posedge clk); #2;
      chk("first_pc", 256'(ex_pc), 256'(32'h40));
      chk("first_valid", 256'(ex_valid), 256'(1));

      // lw x5 followed by a dependent add: one bubble, then the add.
      drive(op(32'h44, 5'd1, 5'd0, 5'd5, 2'b10, 1'b1), 1'b0, 1'b0);
      drive(op(32'h48, 5'd5, 5'd6, 5'd7, 2'b11, 1'b0), 1'b0, 1'b0);
      @(posedge clk); #2;
      chk("lu_bubble_valid", 256'(ex_valid), 256'(0));
      chk("lu_bubble_cnt", 256'(bubble_cnt), 256'(1));
      drive(op(32'h48, 5'd5, 5'd6, 5'd7, 2'b11, 1'b0), 1'b0, 1'b0);
      @(posedge clk); #2;
      chk("lu_after_pc", 256'(ex_pc), 256'(32'h48));

      // Load to x0, and a load whose destination matches only an unused rs2.
      drive(op(32'h4c, 5'd1, 5'd0, 5'd0, 2'b10, 1'b1), 1'b0, 1'b0);
      drive(op(32'h50, 5'd0, 5'd0, 5'd8, 2'b11, 1'b0), 1'b0, 1'b0);
      drive(op(32'h54, 5'd1, 5'd0, 5'd5, 2'b10, 1'b1), 1'b0, 1'b0);
      drive(op(32'h58, 5'd1, 5'd5, 5'd9, 2'b10, 1'b0), 1'b0, 1'b0);
      @(posedge clk); #2;
      chk("unused_rs2_pc", 256'(ex_pc), 256'(32'h58));
      chk("unused_rs2_cnt", 256'(bubble_cnt), 256'(1));

      // Hold for three cycles on ex_stall alone.
      drive(op(32'h80, 5'd1, 5'd2, 5'd3, 2'b11, 1'b0), 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         drive(op(32'h84 + 4 * i, 5'd1, 5'd2, 5'd3, 2'b11, 1'b0), 1'b1, 1'b0);
         @(posedge clk); #2;
         chk("stall_pc", 256'(ex_pc), 256'(32'h80));
      end

      // Flush wins over stall.
      cnt_before = int'(bubble_cnt);
      drive(op(32'h90, 5'd1, 5'd2, 5'd3, 2'b11, 1'b0), 1'b1, 1'b1);
      @(posedge clk); #2;
      chk("flush_stall_regwrite", 256'(ex_regwrite), 256'(0));
      chk("flush_stall_cnt", 256'(bubble_cnt), 256'(cnt_before + 1));

      // Saturation.
      for (int i = 0; i < 20; i++) drive(rand_op($urandom), 1'($urandom), 1'b1);
      @(posedge clk); #2;
      chk("sat_cnt", 256'(bubble_cnt), 256'(CNT_MAX));
      drive(rand_op($urandom), 1'b0, 1'b1);
      @(posedge clk); #2;
      chk("sat_hold", 256'(bubble_cnt), 256'(CNT_MAX));

      // Reset in the middle of a stall.
      drive(op(32'ha0, 5'd1, 5'd2, 5'd3, 2'b11, 1'b0), 1'b0, 1'b0);
      drive(op(32'ha4, 5'd1, 5'd2, 5'd3, 2'b11, 1'b0), 1'b1, 1'b0);
      @(posedge clk); #3;
      do_reset();

      // Eight independent ALU ops back to back.
      for (int i = 0; i < 8; i++) begin
         drive(op(32'h100 + 4 * i, 5'(i + 1), 5'(i + 2), 5'(i + 10), 2'b11, 1'b0), 1'b0, 1'b0);
         @(posedge clk); #2;
         chk("b2b_pc", 256'(ex_pc), 256'(32'h100 + 4 * i));
      end
      chk("b2b_cnt", 256'(bubble_cnt), 256'(0));

      // Random traffic.
      for (int i = 0; i < 400; i++)
         drive(rand_op(32'h1000 + 4 * i), ($urandom_range(0, 6) == 0), ($urandom_range(0, 9) == 0));

      drive('0, 1'b0, 1'b0);
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      @(posedge clk); #3;
      chk("queue_drained", 256'(exp_q.size()), 256'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
